// File: rtl/cmac_tx_axis_arbiter_pkg.sv
// cmac_tx_arb_pkg: shared state type, tuser error bit position and round-robin pick for the CMAC TX arbiter.
package cmac_tx_arb_pkg;
  typedef enum logic [1:0] {IDLE, FWD, DRAIN} arb_state_e;
  localparam int TUSER_ERR_BIT = 0;
  // First valid source after grant_idx, wrapping modulo n_src; returns grant_idx when none is valid.
  function automatic logic [2:0] rr_next(input logic [2:0] grant_idx, input logic [7:0] valid_vec,
                                         input int n_src);
    logic [2:0] pick;
    int idx;
    pick = grant_idx;
    for (int k = 8; k >= 1; k--) begin
      idx = (int'(grant_idx) + k) % n_src;
      if (k <= n_src && valid_vec[idx[2:0]]) pick = idx[2:0];
    end
    return pick;
  endfunction
endpackage

// File: rtl/cmac_tx_axis_arbiter_if.sv
// cmac_tx_axis_arbiter_if: N-lane flattened AXI-Stream bundle; lane i occupies slice i of each vector.
interface cmac_tx_axis_arbiter_if #(
  parameter int N  = 1,
  parameter int DW = 512,
  parameter int KW = 64,
  parameter int UW = 1
);
  logic [N-1:0]    tvalid;
  logic [N-1:0]    tready;
  logic [N*DW-1:0] tdata;
  logic [N*KW-1:0] tkeep;
  logic [N-1:0]    tlast;
  logic [N*UW-1:0] tuser;
  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/cmac_tx_axis_arbiter_skid.sv
// axis_skid_reg: two-entry registered AXIS skid buffer; full rate, registered outputs and ready.
module axis_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  logic         out_valid_q, skid_valid_q;
  logic [W-1:0] out_data_q, skid_data_q;
  assign in_ready_o  = !skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  // The skid entry only fills when the output is stalled, so ready drops one cycle after a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_ready_i || !out_valid_q) begin
      out_valid_q  <= skid_valid_q || in_valid_i;
      out_data_q   <= skid_valid_q ? skid_data_q : in_data_i;
      skid_valid_q <= 1'b0;
    end else if (in_valid_i && !skid_valid_q) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= in_data_i;
    end
  end
endmodule

// File: rtl/cmac_tx_axis_arbiter.sv
// cmac_tx_axis_arbiter: packet-level round-robin merge of N_SRC AXIS sources onto one CMAC TX stream.
// Define CMAC_TX_ARB_STATS_EN to add per-source packet and truncation counters.
module cmac_tx_axis_arbiter
  import cmac_tx_arb_pkg::*;
#(
  parameter int N_SRC         = 2,
  parameter int TDATA_WIDTH   = 512,
  parameter int TKEEP_WIDTH   = 64,
  parameter int TUSER_WIDTH   = 1,
  parameter int MAX_PKT_BEATS = 256,
  localparam int GW = N_SRC > 1 ? $clog2(N_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  cmac_tx_axis_arbiter_if.slave  s_axis,
  cmac_tx_axis_arbiter_if.master m_axis,
  output logic [GW-1:0]          grant_idx,
  output logic                   trunc_pulse
`ifdef CMAC_TX_ARB_STATS_EN
  ,
  output logic [N_SRC*32-1:0]    pkt_count,
  output logic [31:0]            trunc_count
`endif
);
  localparam int CW = 1 + $clog2(MAX_PKT_BEATS);
  localparam int PW = TDATA_WIDTH + TKEEP_WIDTH + 1 + TUSER_WIDTH;
  arb_state_e             state_q;
  logic [GW-1:0]          grant_q, pick;
  logic [CW-1:0]          beat_cnt_q;
  logic                   trunc_q, skid_ready, rdy, fire, last_sel, trunc;
  logic [TUSER_WIDTH-1:0] user_fwd;
  logic [PW-1:0]          out_bundle;
  assign pick        = GW'(rr_next(3'(grant_q), 8'(s_axis.tvalid), N_SRC));
  assign grant_idx   = grant_q;
  assign trunc_pulse = trunc_q;
  always_comb begin
    rdy           = state_q == FWD ? skid_ready : state_q == DRAIN;
    s_axis.tready = rdy ? N_SRC'(1) << grant_q : '0;
    last_sel      = s_axis.tlast[grant_q];
    fire          = s_axis.tvalid[grant_q] && rdy;
    trunc         = state_q == FWD && fire && !last_sel && beat_cnt_q == CW'(MAX_PKT_BEATS - 1);
    user_fwd      = s_axis.tuser[grant_q*TUSER_WIDTH +: TUSER_WIDTH];
    user_fwd[TUSER_ERR_BIT] = user_fwd[TUSER_ERR_BIT] | trunc;
  end
  // Truncated beat leaves as a flagged tlast; the rest of that packet is swallowed in DRAIN.
  axis_skid_reg #(.W(PW)) u_skid (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (state_q == FWD && s_axis.tvalid[grant_q]),
    .in_ready_o  (skid_ready),
    .in_data_i   ({s_axis.tdata[grant_q*TDATA_WIDTH +: TDATA_WIDTH],
                   s_axis.tkeep[grant_q*TKEEP_WIDTH +: TKEEP_WIDTH], last_sel | trunc, user_fwd}),
    .out_valid_o (m_axis.tvalid),
    .out_ready_i (m_axis.tready),
    .out_data_o  (out_bundle)
  );
  assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tuser} = out_bundle;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= GW'(N_SRC - 1);
      beat_cnt_q <= '0;
      trunc_q    <= 1'b0;
    end else begin
      trunc_q <= trunc;
      case (state_q)
        IDLE: if (|s_axis.tvalid) begin
          grant_q <= pick;
          state_q <= FWD;
        end
        FWD: if (fire) begin
          beat_cnt_q <= last_sel || trunc ? '0 : beat_cnt_q + 1'b1;
          state_q    <= last_sel ? IDLE : trunc ? DRAIN : FWD;
        end
        DRAIN: if (fire && last_sel) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef CMAC_TX_ARB_STATS_EN
  // Counted when the closing beat enters the output stage, so a truncated packet counts too.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count   <= '0;
      trunc_count <= '0;
    end else begin
      if (state_q == FWD && fire && (last_sel || trunc))
        pkt_count[grant_q*32 +: 32] <= pkt_count[grant_q*32 +: 32] + 32'd1;
      if (trunc) trunc_count <= trunc_count + 32'd1;
    end
  end
`endif
endmodule
